// File: rtl/pipe_or_pkg.sv
// rtl/pipe_or_pkg.sv - shared latency/width helpers for pipe_or and its scheduler
// Contents:
//   PIPE_OR_FANIN        inputs OR-ed per tree node at each pipeline stage
//   pipe_or_latency(w)   number of register stages in pipe_or for a w-bit vector
//   pipe_or_stage_width  number of partial-OR bits left after a given stage
//   id_width(n)          bits needed to name one of n requesters (at least 1)
package pipe_or_pkg;

  localparam int PIPE_OR_FANIN = 6;

  function automatic int pipe_or_latency(input int width);
    if (width <= 6) return 1;
    else if (width <= 36) return 2;
    else if (width <= 216) return 3;
    else return 4;
  endfunction

  function automatic int pipe_or_stage_width(input int width, input int stage);
    int w;
    w = width;
    for (int s = 0; s < stage; s++) w = (w + PIPE_OR_FANIN - 1) / PIPE_OR_FANIN;
    return w;
  endfunction

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_or.sv
// rtl/pipe_or.sv - pipelined wide OR reduction, one registered 6-input level per stage
// Ports:
//   clk  in   clock, rising edge (no reset: contents are qualified externally)
//   a    in   WIDTH-bit vector to reduce
//   out  out  |a, pipe_or_latency(WIDTH) cycles after a is presented
module pipe_or
  import pipe_or_pkg::*;
#(
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  output logic             out
);

  localparam int LATENCY = pipe_or_latency(WIDTH);

  if (WIDTH < 1 || WIDTH > 1296) begin : g_chk_width
    $error("pipe_or: WIDTH must be in 1..1296");
  end

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int NI = pipe_or_stage_width(WIDTH, s);
    localparam int NO = pipe_or_stage_width(WIDTH, s + 1);

    logic [NI-1:0]               in_v;
    logic [NO*PIPE_OR_FANIN-1:0] pad;
    logic [NO-1:0]               q;

    if (s == 0) begin : g_first
      assign in_v = a;
    end else begin : g_next
      assign in_v = g_stage[s-1].q;
    end

    // Zero-pad the last partial group so every node sees a full fan-in.
    always_comb begin
      pad = '0;
      pad[NI-1:0] = in_v;
    end

    always_ff @(posedge clk) begin
      for (int o = 0; o < NO; o++) q[o] <= |pad[o*PIPE_OR_FANIN +: PIPE_OR_FANIN];
    end
  end

  assign out = g_stage[LATENCY-1].q[0];

endmodule

// File: rtl/pipe_or_sched.sv
// rtl/pipe_or_sched.sv - round-robin sharing of one pipe_or among NREQ requesters
// Ports:
//   clk        in   clock, rising edge
//   sclr       in   synchronous active-high clear; drops all in-flight and queued results
//   req_valid  in   per-requester request valid
//   req_data   in   requester i vector at [i*WIDTH +: WIDTH]
//   req_ready  out  one-hot (or zero) grant
//   res_valid  out  result FIFO head valid
//   res_ready  in   consumer accepts the head
//   res_or     out  OR reduction of the granted vector
//   res_id     out  requester index that produced the result
//   busy       out  transaction in flight or queued
module pipe_or_sched
  import pipe_or_pkg::*;
#(
  parameter int WIDTH      = 100,
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        sclr,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*WIDTH-1:0]       req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_or,
  output logic [id_width(NREQ)-1:0]   res_id,
  output logic                        busy
);

  localparam int LATENCY = pipe_or_latency(WIDTH);
  localparam int IDW     = id_width(NREQ);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int PW      = (FIFO_DEPTH <= 1) ? 1 : $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  if (NREQ < 2) begin : g_chk_nreq
    $error("pipe_or_sched: NREQ must be >= 2");
  end
  if (FIFO_DEPTH < 1) begin : g_chk_depth
    $error("pipe_or_sched: FIFO_DEPTH must be >= 1");
  end

  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]    in_flight_q, in_flight_d;
  logic [CW-1:0]    fifo_count_q, fifo_count_d;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [LATENCY:0] tag_v_q;
  logic [IDW-1:0]   tag_id_q [LATENCY+1];
  logic [WIDTH-1:0] launch_q;
  logic             mem_or_q [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id_q [FIFO_DEPTH];

  logic [IDW-1:0]   sel_id;
  logic             sel_found;
  logic             credit_ok;
  logic             hs;
  logic             wr;
  logic             pop;
  logic             pipe_out;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin: first valid requester strictly after the last granted one.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!sel_found && req_valid[(int'(last_grant_q) + off) % NREQ]) begin
        sel_found = 1'b1;
        sel_id    = IDW'((int'(last_grant_q) + off) % NREQ);
      end
    end
  end

  // Registered counts only, so a pop returns its credit one cycle later.
  assign credit_ok = ({1'b0, in_flight_q} + {1'b0, fifo_count_q}) < DEPTH_C;
  assign hs        = sel_found & credit_ok & ~sclr;
  assign req_ready = hs ? (NREQ'(1) << sel_id) : '0;

  assign wr  = tag_v_q[LATENCY];
  assign pop = res_valid & res_ready;

  always_comb begin
    last_grant_d = hs ? sel_id : last_grant_q;
    in_flight_d  = in_flight_q + CW'(hs) - CW'(wr);
    fifo_count_d = fifo_count_q + CW'(wr) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      last_grant_q <= IDW'(NREQ - 1);
      in_flight_q  <= '0;
      fifo_count_q <= '0;
      tag_v_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      in_flight_q  <= in_flight_d;
      fifo_count_q <= fifo_count_d;
      tag_v_q      <= {tag_v_q[LATENCY-1:0], hs};
      if (wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Datapath without reset: launch data, tag ids and FIFO storage are only
  // ever observed under a valid bit that sclr clears.
  always_ff @(posedge clk) begin
    if (hs) launch_q <= req_data[int'(sel_id)*WIDTH +: WIDTH];
    tag_id_q[0] <= sel_id;
    for (int i = 1; i <= LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
    if (wr) begin
      mem_or_q[wr_ptr_q] <= pipe_out;
      mem_id_q[wr_ptr_q] <= tag_id_q[LATENCY];
    end
  end

  pipe_or #(.WIDTH(WIDTH)) u_pipe_or (
    .clk (clk),
    .a   (launch_q),
    .out (pipe_out)
  );

  // Head is gated so stale storage never shows while the FIFO is empty.
  assign res_valid = (fifo_count_q != '0);
  assign res_or    = res_valid & mem_or_q[rd_ptr_q];
  assign res_id    = res_valid ? mem_id_q[rd_ptr_q] : '0;
  assign busy      = (in_flight_q != '0) | (fifo_count_q != '0);

endmodule

// File: tb/tb_pipe_or_sched.sv
// tb/tb_pipe_or_sched.sv - directed bench for pipe_or_sched
module tb_pipe_or_sched;

  localparam int W = 100;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           sclr;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready;
  logic           res_or;
  logic [1:0]     res_id;
  logic           busy;

  logic [1:0] sw_valid;
  logic [7:0] sw_rdy;
  logic [3:0] sw_res_valid, sw_res_or, sw_id, sw_busy;

  int passed, total;

  always #5 clk = ~clk;

  pipe_or_sched #(.WIDTH(W), .NREQ(N), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .sclr(sclr), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_or(res_or), .res_id(res_id), .busy(busy)
  );

  pipe_or_sched #(.WIDTH(6), .NREQ(2), .FIFO_DEPTH(8)) u_sw0 (
    .clk(clk), .sclr(sclr), .req_valid(sw_valid), .req_data({12{1'b1}}),
    .req_ready(sw_rdy[1:0]), .res_valid(sw_res_valid[0]), .res_ready(1'b1),
    .res_or(sw_res_or[0]), .res_id(sw_id[0:0]), .busy(sw_busy[0])
  );
  pipe_or_sched #(.WIDTH(36), .NREQ(2), .FIFO_DEPTH(8)) u_sw1 (
    .clk(clk), .sclr(sclr), .req_valid(sw_valid), .req_data({72{1'b1}}),
    .req_ready(sw_rdy[3:2]), .res_valid(sw_res_valid[1]), .res_ready(1'b1),
    .res_or(sw_res_or[1]), .res_id(sw_id[1:1]), .busy(sw_busy[1])
  );
  pipe_or_sched #(.WIDTH(216), .NREQ(2), .FIFO_DEPTH(8)) u_sw2 (
    .clk(clk), .sclr(sclr), .req_valid(sw_valid), .req_data({432{1'b1}}),
    .req_ready(sw_rdy[5:4]), .res_valid(sw_res_valid[2]), .res_ready(1'b1),
    .res_or(sw_res_or[2]), .res_id(sw_id[2:2]), .busy(sw_busy[2])
  );
  pipe_or_sched #(.WIDTH(217), .NREQ(2), .FIFO_DEPTH(8)) u_sw3 (
    .clk(clk), .sclr(sclr), .req_valid(sw_valid), .req_data({434{1'b1}}),
    .req_ready(sw_rdy[7:6]), .res_valid(sw_res_valid[3]), .res_ready(1'b1),
    .res_or(sw_res_or[3]), .res_id(sw_id[3:3]), .busy(sw_busy[3])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    req_valid = '0;
    sw_valid = '0;
    tick();
    sclr = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    v = '0;
    case ($urandom_range(0, 2))
      0: v = '0;
      1: v[$urandom_range(0, W-1)] = 1'b1;
      default: for (int b = 0; b < W; b++) v[b] = 1'($urandom_range(0, 1));
    endcase
    return v;
  endfunction

  task automatic test_reset();
    sclr = 1'b1;
    req_valid = '1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready cyc %0d got %b exp 0000", i, req_ready); else passed++;
      total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid cyc %0d got %b exp 0", i, res_valid); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy cyc %0d got %b exp 0", i, busy); else passed++;
      total++; if (res_id !== 2'd0) $display("FAIL reset_res_id cyc %0d got %0d exp 0", i, res_id); else passed++;
      total++; if (res_or !== 1'b0) $display("FAIL reset_res_or cyc %0d got %b exp 0", i, res_or); else passed++;
      tick();
    end
    sclr = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    res_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      req_data = '0;
      if (t == 1) req_data[2*W+99] = 1'b1;
      req_valid = 4'b0100;
      #1;
      total++; if (req_ready !== 4'b0100) $display("FAIL single_grant t%0d got %b exp 0100", t, req_ready); else passed++;
      tick();
      req_valid = '0;
      for (int c = 1; c <= 4; c++) begin
        tick();
        total++; if (res_valid !== (c == 4)) $display("FAIL single_latency t%0d cyc %0d got %b exp %b", t, c, res_valid, (c == 4)); else passed++;
      end
      total++; if (res_or !== 1'(t)) $display("FAIL single_res_or t%0d got %b exp %0d", t, res_or, t); else passed++;
      total++; if (res_id !== 2'd2) $display("FAIL single_res_id t%0d got %0d exp 2", t, res_id); else passed++;
    end
  endtask

  task automatic test_fairness();
    logic [2:0] q[$];
    logic [2:0] head;
    int exp_id;
    exp_id = 0;
    do_reset();
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 28; cyc++) begin
      total++; if (res_valid !== (cyc >= 5 && cyc <= 24)) $display("FAIL fair_res_valid cyc %0d got %b exp %b", cyc, res_valid, (cyc >= 5 && cyc <= 24)); else passed++;
      if (res_valid === 1'b1 && q.size() > 0) begin
        head = q.pop_front();
        total++; if ({res_or, res_id} !== head) $display("FAIL fair_result cyc %0d got or=%b id=%0d exp or=%b id=%0d", cyc, res_or, res_id, head[2], head[1:0]); else passed++;
      end
      if (cyc < 20) begin
        req_valid = '1;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = rand_vec();
        #1;
        total++; if (req_ready !== 4'(1 << exp_id)) $display("FAIL fair_grant cyc %0d got %b exp id %0d", cyc, req_ready, exp_id); else passed++;
        q.push_back({|req_data[exp_id*W +: W], 2'(exp_id)});
        exp_id = (exp_id + 1) % N;
      end else begin
        req_valid = '0;
      end
      tick();
    end
    total++; if (q.size() != 0) $display("FAIL fair_drain left %0d exp 0", q.size()); else passed++;
  endtask

  task automatic set_bp_data();
    req_data = '0;
    req_data[1*W] = 1'b1;
    req_data[3*W+99] = 1'b1;
  endtask

  task automatic test_backpressure();
    do_reset();
    res_ready = 1'b0;
    set_bp_data();
    req_valid = '1;
    #1;
    for (int n = 0; n < 8; n++) begin
      total++; if (req_ready !== 4'(1 << (n % 4))) $display("FAIL bp_grant n%0d got %b exp id %0d", n, req_ready, n % 4); else passed++;
      tick();
    end
    for (int n = 0; n < 6; n++) begin
      total++; if (req_ready !== 4'b0) $display("FAIL bp_stall n%0d got %b exp 0000", n, req_ready); else passed++;
      tick();
    end
    res_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (n == 0) begin
        total++; if (req_ready !== 4'b0) $display("FAIL bp_prepop got %b exp 0000", req_ready); else passed++;
      end
      if (n == 1) begin
        total++; if (req_ready !== 4'b0001) $display("FAIL bp_resume got %b exp 0001", req_ready); else passed++;
        req_valid = '0;
      end
      total++; if (res_valid !== 1'b1) $display("FAIL bp_res_valid n%0d got %b exp 1", n, res_valid); else passed++;
      total++; if (res_id !== 2'(n % 4)) $display("FAIL bp_res_id n%0d got %0d exp %0d", n, res_id, n % 4); else passed++;
      total++; if (res_or !== 1'(n % 2)) $display("FAIL bp_res_or n%0d got %b exp %0d", n, res_or, n % 2); else passed++;
      tick();
    end
    total++; if (res_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", res_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL bp_idle got %b exp 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    res_ready = 1'b0;
    set_bp_data();
    req_valid = '1;
    #1;
    for (int n = 0; n < 5; n++) tick();
    req_valid = '0;
    tick();
    total++; if (res_valid !== 1'b1) $display("FAIL mid_pre_valid got %b exp 1", res_valid); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL mid_pre_busy got %b exp 1", busy); else passed++;
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    total++; if (res_valid !== 1'b0) $display("FAIL mid_res_valid got %b exp 0", res_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else passed++;
    total++; if (res_id !== 2'd0) $display("FAIL mid_res_id got %0d exp 0", res_id); else passed++;
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++; if (res_valid !== 1'b0) $display("FAIL mid_ghost cyc %0d got %b exp 0", c, res_valid); else passed++;
    end
    req_valid = '1;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant got %b exp 0001", req_ready); else passed++;
    req_valid = '0;
  endtask

  task automatic test_latency_sweep();
    int lat [4];
    int exp_lat [4];
    exp_lat = '{2, 3, 4, 5};
    lat = '{0, 0, 0, 0};
    do_reset();
    sw_valid = 2'b01;
    #1;
    for (int j = 0; j < 4; j++) begin
      total++; if (sw_rdy[2*j +: 2] !== 2'b01) $display("FAIL sweep_grant inst %0d got %b exp 01", j, sw_rdy[2*j +: 2]); else passed++;
    end
    tick();
    sw_valid = '0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      for (int j = 0; j < 4; j++) begin
        if (sw_res_valid[j] === 1'b1 && lat[j] == 0) begin
          lat[j] = c;
          total++; if ({sw_res_or[j], sw_id[j]} !== 2'b10) $display("FAIL sweep_result inst %0d got or=%b id=%b exp or=1 id=0", j, sw_res_or[j], sw_id[j]); else passed++;
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      total++; if (lat[j] != exp_lat[j]) $display("FAIL sweep_latency inst %0d got %0d exp %0d", j, lat[j], exp_lat[j]); else passed++;
    end
    total++; if (sw_busy !== 4'b0) $display("FAIL sweep_idle got %b exp 0000", sw_busy); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    sclr = 1'b1;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b0;
    sw_valid = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_latency_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_or_sched.md
# pipe_or_sched

Round-robin scheduler that shares one pipelined wide-OR reduction (`pipe_or`) among `NREQ` requesters. It grants at most one request per cycle into the shared OR tree. A matched tag pipeline carries the requester id alongside the data. Results return in grant order through a credit-protected result FIFO with valid/ready backpressure. The block sits between several reduction clients and a single `pipe_or` instance, so the OR tree is instantiated once instead of per client.

## Interface
Parameters:
- `WIDTH`, 100: bits per reduction vector.
- `NREQ`, 4: number of requesters, ≥2.
- `FIFO_DEPTH`, 8: result FIFO entries, ≥1. Also the outstanding-transaction limit.
- `LATENCY` (localparam): `pipe_or` latency from `pipe_or_pkg::pipe_or_latency(WIDTH)`.
  - 1 if WIDTH≤6, 2 if ≤36, 3 if ≤216, else 4.
- `IDW` (localparam): max(1, $clog2(NREQ)).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `sclr`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_data`  in  NREQ*WIDTH  requester i vector at [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ  one-hot or zero grant; handshake = valid & ready at a rising edge.
- `res_valid`  out  1  result FIFO head valid.
- `res_ready`  in  1  consumer accepts the head.
- `res_or`  out  1  OR-reduction of the granted vector.
- `res_id`  out  IDW  index of the requester that produced the result.
- `busy`  out  1  any transaction in flight or queued.

## Operation
- Credit rule: a grant is allowed only when `in_flight + fifo_count < FIFO_DEPTH`, using registered counts.
- Credit timing: a pop frees its credit on the next cycle, not the same cycle.
- Arbitration: round-robin. The search starts at `last_grant+1` mod NREQ.
  - `last_grant` updates only on a handshake.
  - After reset `last_grant = NREQ-1`, so requester 0 has first priority.
- `req_ready` is combinational from `req_valid` and the pointer. It is all-zero when credits are exhausted or `sclr` is high.
- Requesters must not make `req_valid` depend on `req_ready`.
- Launch: on a handshake the selected vector is captured into a launch register feeding `pipe_or.a`.
  - id and valid enter a tag shift register of length LATENCY+1.
  - When there is no handshake, the tag valid shifts in 0. The launch register may hold stale data.
- Writeback: when the tag valid exits, `{pipe_or.out, id}` is written to the FIFO.
  - The FIFO is show-ahead with no bypass.
  - Overflow is impossible by the credit rule.
- Pop: `res_valid & res_ready`.
- Counters (all variants assume registered counts):
  - `in_flight`: +1 on handshake, −1 on FIFO write. Both in one cycle means no change.
  - `fifo_count`: +1 on write, −1 on pop. Simultaneous write and pop is legal, including when full.
- `busy = (in_flight != 0) | (fifo_count != 0)`.
- `sclr` clears `last_grant`, both counters, the tag valid pipeline and the FIFO pointers.
  - In-flight and queued results are discarded.
  - `pipe_or` has no reset; its contents are don't-care because tag valids are cleared.
- Reset values: `req_ready=0`, `res_valid=0`, `res_or=0`, `res_id=0`, `busy=0`.

## Timing
- Handshake at edge k → FIFO write at edge k+LATENCY+1 → `res_valid` high in cycle k+LATENCY+1, when the FIFO was empty.
- For WIDTH=100 (LATENCY=3): first result is visible 4 cycles after the grant edge.
- Each transaction holds a credit for LATENCY+2 cycles with `res_ready` held high.
- Sustained one grant per cycle requires FIFO_DEPTH ≥ LATENCY+2. The default of 8 satisfies this for all widths.
- Results are in strict grant order; there is no reordering.
- `sclr` is sampled at the edge. During the cycle after that edge all outputs hold their reset values.
  - No result granted before reset may ever appear afterwards.

## Structure
- `pipe_or_pkg`:
  - `pipe_or_latency(width)` function, shared with `pipe_or` and its bench so the latency formula exists once.
  - `id_width(n)` function.
- One sub-module: the existing `pipe_or #(.WIDTH(WIDTH))`, instanced once.
- Arbiter, tag pipeline, counters and FIFO are written inline.
- Elaboration checks: NREQ≥2, FIFO_DEPTH≥1.

## Test plan
- Reset/idle: hold `sclr` 2 cycles with all `req_valid=1` → `req_ready=0`, `res_valid=0`, `busy=0`, `res_id=0` throughout.
- Single requester, WIDTH=100: requester 2 sends all-zeros, then only bit 99 set → results 0 then 1, both `res_id=2`, each `res_valid` exactly 4 cycles after its handshake edge.
- Fairness/throughput: all 4 valid continuously, `res_ready=1`, random vectors → grants 0,1,2,3,0,… one per cycle with no bubbles; `res_or` matches a reference |vector model in order.
- Backpressure: `res_ready=0`, all requesting → exactly 8 handshakes, then `req_ready=0`. Raise `res_ready` → 8 ordered results, then grants resume one cycle after the first pop.
- Reset mid-operation: `sclr` pulse with 3 in flight and 2 queued → next cycle `res_valid=0` and `busy=0`. No result emerges in the following 6 cycles. The first post-reset grant goes to requester 0.
- Latency sweep: WIDTH = 6, 36, 216, 217 → grant-to-`res_valid` of 2, 3, 4, 5 cycles respectively.
